// File: rtl/dma_axi_master.sv
// dma_axi_master: AXI master DMA engine. It reads a block of 32-bit words in
// INCR bursts into a local beat buffer, then writes the buffer out as a burst
// to the destination. Bursts never cross a 4KB boundary, and only one burst is
// in flight at a time.
// Optional build macro DMA_ERR_ABORT_EN: when it is defined, any error response
// ends the transfer after the current burst's write response.
module dma_axi_master #(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ARVALID_M,
  input  logic             ARREADY_M,
  output logic [31:0]      ARADDR_M,
  output logic [3:0]       ARLEN_M,
  input  logic             RVALID_M,
  output logic             RREADY_M,
  input  logic [31:0]      RDATA_M,
  input  logic [1:0]       RRESP_M,
  input  logic             RLAST_M,
  output logic             AWVALID_M,
  input  logic             AWREADY_M,
  output logic [31:0]      AWADDR_M,
  output logic [3:0]       AWLEN_M,
  output logic             WVALID_M,
  input  logic             WREADY_M,
  output logic [31:0]      WDATA_M,
  output logic             WLAST_M,
  input  logic             BVALID_M,
  output logic             BREADY_M,
  input  logic [1:0]       BRESP_M
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

`ifdef DMA_ERR_ABORT_EN
  localparam bit ABORT_ON_ERR = 1'b1;
`else
  localparam bit ABORT_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]      r_src, r_dst, w_src_nxt, w_dst_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [CW-1:0]    r_chunk, w_chunk_nxt, w_chunk_m1;
  logic [CW-1:0]    r_idx, w_idx_nxt;
  logic [31:0]      r_buf [MAX_BURST];
  logic [31:0]      w_step;

  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_wlast, r_bready;
  logic        r_busy, r_done, r_err;
  logic [31:0] r_araddr, r_awaddr, r_wdata;
  logic [3:0]  r_arlen, r_awlen;

  logic w_arhs, w_rhs, w_awhs, w_whs, w_bhs, w_last_idx, w_berr, w_accept;

  // Burst size: remaining words, capped by the buffer depth and by the
  // distance of both addresses to their next 4KB boundary.
  function automatic logic [CW-1:0] f_chunk(input logic [31:0] s,
                                            input logic [31:0] d,
                                            input logic [LEN_W-1:0] rem);
    logic [31:0] c, ls, ld;
    c  = 32'(rem);
    ls = (32'd4096 - {20'd0, s[11:0]}) >> 2;
    ld = (32'd4096 - {20'd0, d[11:0]}) >> 2;
    if (c > 32'(MAX_BURST)) c = 32'(MAX_BURST);
    if (ls < c) c = ls;
    if (ld < c) c = ld;
    return c[CW-1:0];
  endfunction

  assign w_arhs     = r_arvalid & ARREADY_M;
  assign w_rhs      = r_rready & RVALID_M;
  assign w_awhs     = r_awvalid & AWREADY_M;
  assign w_whs      = r_wvalid & WREADY_M;
  assign w_bhs      = r_bready & BVALID_M;
  assign w_berr     = (BRESP_M != 2'b00);
  assign w_chunk_m1 = r_chunk - CW'(1);
  assign w_last_idx = (r_idx == w_chunk_m1);
  assign w_step     = 32'(r_chunk) << 2;
  assign w_accept   = (r_state == S_IDLE) && start;

  // Next values of the address/count registers, used both to update them and
  // to size the upcoming burst on entry to AR.
  always_comb begin
    w_src_nxt = r_src;
    w_dst_nxt = r_dst;
    w_rem_nxt = r_rem;
    if (w_accept && (len != '0)) begin
      w_src_nxt = src_addr;
      w_dst_nxt = dst_addr;
      w_rem_nxt = len;
    end else if ((r_state == S_B) && w_bhs) begin
      w_src_nxt = r_src + w_step;
      w_dst_nxt = r_dst + w_step;
      w_rem_nxt = r_rem - LEN_W'(r_chunk);
    end
    w_chunk_nxt = f_chunk(w_src_nxt, w_dst_nxt, w_rem_nxt);
  end

  // Next state and next beat index.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (start) w_state_nxt = (len == '0) ? S_DONE : S_AR;
      end
      S_AR: if (w_arhs) w_state_nxt = S_R;
      S_R: begin
        if (w_rhs) begin
          if (RLAST_M || w_last_idx) begin
            w_state_nxt = S_AW;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + CW'(1);
          end
        end
      end
      S_AW: if (w_awhs) w_state_nxt = S_W;
      S_W: begin
        if (w_whs) begin
          if (w_last_idx) begin
            w_state_nxt = S_B;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + CW'(1);
          end
        end
      end
      S_B: begin
        if (w_bhs) begin
          w_state_nxt = (w_rem_nxt != '0) ? S_AR : S_DONE;
          if (ABORT_ON_ERR && (r_err || w_berr)) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Control outputs, error flag and counters, registered from the next state.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_rem     <= '0;
      r_chunk   <= '0;
    end else begin
      r_arvalid <= (w_state_nxt == S_AR);
      r_rready  <= (w_state_nxt == S_R);
      r_awvalid <= (w_state_nxt == S_AW);
      r_wvalid  <= (w_state_nxt == S_W);
      r_wlast   <= (w_state_nxt == S_W) && (w_idx_nxt == w_chunk_m1);
      r_bready  <= (w_state_nxt == S_B);
      r_busy    <= (w_state_nxt inside {S_AR, S_R, S_AW, S_W, S_B}) ||
                   ((w_state_nxt == S_DONE) && (r_state != S_IDLE));
      r_done    <= (w_state_nxt == S_DONE);
      if (w_accept)
        r_err <= 1'b0;
      else if (((r_state == S_R) && w_rhs && (RRESP_M != 2'b00)) ||
               ((r_state == S_B) && w_bhs && w_berr))
        r_err <= 1'b1;
      r_idx <= w_idx_nxt;
      r_rem <= w_rem_nxt;
      if ((w_state_nxt == S_AR) && (r_state != S_AR)) r_chunk <= w_chunk_nxt;
    end
  end

  // Addresses, burst lengths and the beat buffer (datapath, not reset).
  always_ff @(posedge ACLK) begin
    r_src <= w_src_nxt;
    r_dst <= w_dst_nxt;
    if ((w_state_nxt == S_AR) && (r_state != S_AR)) begin
      r_araddr <= w_src_nxt;
      r_arlen  <= 4'(w_chunk_nxt - CW'(1));
    end
    if ((w_state_nxt == S_AW) && (r_state != S_AW)) begin
      r_awaddr <= r_dst;
      r_awlen  <= 4'(w_chunk_m1);
    end
    if ((r_state == S_R) && w_rhs) r_buf[r_idx[IW-1:0]] <= RDATA_M;
    r_wdata <= r_buf[w_idx_nxt[IW-1:0]];
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign ARVALID_M = r_arvalid;
  assign ARADDR_M  = r_araddr;
  assign ARLEN_M   = r_arlen;
  assign RREADY_M  = r_rready;
  assign AWVALID_M = r_awvalid;
  assign AWADDR_M  = r_awaddr;
  assign AWLEN_M   = r_awlen;
  assign WVALID_M  = r_wvalid;
  assign WDATA_M   = r_wdata;
  assign WLAST_M   = r_wlast;
  assign BREADY_M  = r_bready;

endmodule

// File: tb/tb_dma_axi_master.sv
// Directed testbench for dma_axi_master with a small reactive AXI slave.
module tb_dma_axi_master;

  logic        ACLK, ARESETn, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic        ARVALID_M, ARREADY_M, RVALID_M, RREADY_M, RLAST_M;
  logic [31:0] ARADDR_M, RDATA_M, AWADDR_M, WDATA_M;
  logic [3:0]  ARLEN_M, AWLEN_M;
  logic [1:0]  RRESP_M, BRESP_M;
  logic        AWVALID_M, AWREADY_M, WVALID_M, WREADY_M, WLAST_M;
  logic        BVALID_M, BREADY_M;

  dma_axi_master #(.MAX_BURST(16), .LEN_W(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
    .RLAST_M(RLAST_M),
    .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
    .WVALID_M(WVALID_M), .WREADY_M(WREADY_M), .WDATA_M(WDATA_M), .WLAST_M(WLAST_M),
    .BVALID_M(BVALID_M), .BREADY_M(BREADY_M), .BRESP_M(BRESP_M)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // slave configuration (written by the stimulus only)
  int ar_delay  = 0;
  bit w_toggle  = 0;
  int err_burst = -1;

  // slave state and logs (written by the slave only)
  int          ar_cnt, rbeats, b_cnt;
  bit          bpend, ar_seen, w_hold, w_tog;
  logic [31:0] raddr, ar_first, w_held;
  int          done_cnt, busy_cnt, arv_cnt, awv_cnt;
  logic [31:0] ar_addr_q[$], aw_addr_q[$], wd_q[$];
  logic [3:0]  ar_len_q[$], aw_len_q[$];
  logic        wl_q[$];

  initial begin
    ar_cnt = 0; rbeats = 0; b_cnt = 0; bpend = 0; ar_seen = 0; w_hold = 0; w_tog = 0;
    done_cnt = 0; busy_cnt = 0; arv_cnt = 0; awv_cnt = 0;
  end

  // Slave: drive inputs and log handshakes on the falling edge.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      ARREADY_M = 0; RVALID_M = 0; RDATA_M = 0; RRESP_M = 0; RLAST_M = 0;
      AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = 0;
      ar_cnt = 0; rbeats = 0; bpend = 0; ar_seen = 0; w_hold = 0;
    end else begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (ARVALID_M) arv_cnt++;
      if (AWVALID_M) awv_cnt++;
      BVALID_M = bpend;
      BRESP_M  = (bpend && b_cnt == err_burst) ? 2'b10 : 2'b00;
      if (bpend && BREADY_M) begin bpend = 0; b_cnt++; end
      RVALID_M = (rbeats > 0);
      RDATA_M  = mem(raddr);
      RLAST_M  = (rbeats == 1);
      RRESP_M  = 2'b00;
      if (RVALID_M && RREADY_M) begin raddr = raddr + 32'd4; rbeats--; end
      if (w_hold && WVALID_M) check("wdata_hold", WDATA_M, w_held);
      w_tog    = ~w_tog;
      WREADY_M = w_toggle ? w_tog : 1'b1;
      if (WVALID_M && WREADY_M) begin
        wd_q.push_back(WDATA_M);
        wl_q.push_back(WLAST_M);
        if (WLAST_M) bpend = 1;
        w_hold = 0;
      end else begin
        w_hold = WVALID_M;
        w_held = WDATA_M;
      end
      if (ARVALID_M && !ar_seen) begin ar_seen = 1; ar_first = ARADDR_M; end
      ARREADY_M = ARVALID_M && (ar_cnt >= ar_delay);
      if (ARVALID_M && !ARREADY_M) ar_cnt++;
      else if (ARVALID_M) begin
        if (ar_delay > 0) check("araddr_hold", ARADDR_M, ar_first);
        ar_addr_q.push_back(ARADDR_M);
        ar_len_q.push_back(ARLEN_M);
        rbeats = int'(ARLEN_M) + 1;
        raddr = ARADDR_M;
        ar_cnt = 0;
        ar_seen = 0;
      end
      AWREADY_M = AWVALID_M;
      if (AWVALID_M) begin
        aw_addr_q.push_back(AWADDR_M);
        aw_len_q.push_back(AWLEN_M);
      end
    end
  end

  int ar_b, aw_b, wd_b, done_b, arv_b, awv_b, busy_b;

  task automatic snap();
    ar_b = ar_addr_q.size(); aw_b = aw_addr_q.size(); wd_b = wd_q.size();
    done_b = done_cnt; arv_b = arv_cnt; awv_b = awv_cnt; busy_b = busy_cnt;
  endtask

  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int repulse);
    int cyc;
    bit got;
    snap();
    @(negedge ACLK); src_addr = s; dst_addr = d; len = n; start = 1;
    @(negedge ACLK); start = 0;
    cyc = 0; got = 0;
    while (!got && cyc < 3000) begin
      if (repulse > 0 && cyc == repulse) begin
        check("busy_mid", 32'(busy), 32'd1);
        src_addr = 32'h8000; dst_addr = 32'h9000; len = 16'd3; start = 1;
      end else start = 0;
      if (done) got = 1;
      @(negedge ACLK); cyc++;
    end
    start = 0;
    check("done_seen", 32'(got), 32'd1);
    repeat (6) @(negedge ACLK);
    check("done_pulses", 32'(done_cnt - done_b), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic chk_addr(input string tag, input bit is_aw, input int k,
                          input logic [31:0] ea, input logic [3:0] el);
    int idx;
    idx = (is_aw ? aw_b : ar_b) + k;
    if (idx < (is_aw ? aw_addr_q.size() : ar_addr_q.size())) begin
      check({tag, "_addr"}, is_aw ? aw_addr_q[idx] : ar_addr_q[idx], ea);
      check({tag, "_len"}, {28'd0, is_aw ? aw_len_q[idx] : ar_len_q[idx]}, {28'd0, el});
    end else check({tag, "_missing"}, 32'd0, 32'd1);
  endtask

  task automatic chk_counts(input string tag, input int nar, input int naw, input int nbeats);
    check({tag, "_ar_cnt"}, 32'(ar_addr_q.size() - ar_b), 32'(nar));
    check({tag, "_aw_cnt"}, 32'(aw_addr_q.size() - aw_b), 32'(naw));
    check({tag, "_beats"}, 32'(wd_q.size() - wd_b), 32'(nbeats));
  endtask

  task automatic chk_data(input string tag, input logic [31:0] s0, input int n);
    for (int i = 0; i < n; i++)
      if (wd_b + i < wd_q.size()) check({tag, "_wdata"}, wd_q[wd_b + i], mem(s0 + 32'(4 * i)));
  endtask

  task automatic chk_last(input string tag, input int pos);
    if (wd_b + pos < wl_q.size()) check({tag, "_wlast"}, 32'(wl_q[wd_b + pos]), 32'd1);
    else check({tag, "_wlast_missing"}, 32'd0, 32'd1);
  endtask

  function automatic int last_count();
    int c;
    c = 0;
    for (int i = wd_b; i < wl_q.size(); i++) if (wl_q[i]) c++;
    return c;
  endfunction

  initial begin
    ARESETn = 0; start = 0; src_addr = 0; dst_addr = 0; len = 0;
    repeat (3) @(negedge ACLK);
    check("reset_ctrl", {24'd0, busy, done, err, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M},
          32'd0);
    ARESETn = 1;
    repeat (2) @(negedge ACLK);

    // single 4-beat burst
    do_xfer(32'h1000, 32'h2000, 16'd4, 0);
    chk_counts("c1", 1, 1, 4);
    chk_addr("c1_ar", 0, 0, 32'h1000, 4'd3);
    chk_addr("c1_aw", 1, 0, 32'h2000, 4'd3);
    chk_data("c1", 32'h1000, 4);
    chk_last("c1", 3);
    check("c1_wlast_cnt", 32'(last_count()), 32'd1);
    check("c1_err", 32'(err), 32'd0);

    // 20 words: 16 + 4
    do_xfer(32'h1000, 32'h2000, 16'd20, 0);
    chk_counts("c2", 2, 2, 20);
    chk_addr("c2_ar0", 0, 0, 32'h1000, 4'd15);
    chk_addr("c2_ar1", 0, 1, 32'h1040, 4'd3);
    chk_addr("c2_aw0", 1, 0, 32'h2000, 4'd15);
    chk_addr("c2_aw1", 1, 1, 32'h2040, 4'd3);
    chk_data("c2", 32'h1000, 20);
    chk_last("c2_b0", 15);
    chk_last("c2_b1", 19);
    check("c2_wlast_cnt", 32'(last_count()), 32'd2);

    // 4KB boundary split: 2 + 6
    do_xfer(32'h1FF8, 32'h3000, 16'd8, 0);
    chk_counts("c3", 2, 2, 8);
    chk_addr("c3_ar0", 0, 0, 32'h1FF8, 4'd1);
    chk_addr("c3_ar1", 0, 1, 32'h2000, 4'd5);
    chk_addr("c3_aw0", 1, 0, 32'h3000, 4'd1);
    chk_addr("c3_aw1", 1, 1, 32'h3008, 4'd5);
    chk_data("c3", 32'h1FF8, 8);

    // zero length: done next cycle, no bus traffic, never busy
    snap();
    @(negedge ACLK); src_addr = 32'h1000; dst_addr = 32'h2000; len = 16'd0; start = 1;
    @(negedge ACLK); start = 0;
    check("c4_done", 32'(done), 32'd1);
    @(negedge ACLK);
    check("c4_done_off", 32'(done), 32'd0);
    repeat (3) @(negedge ACLK);
    check("c4_arvalid", 32'(arv_cnt - arv_b), 32'd0);
    check("c4_awvalid", 32'(awv_cnt - awv_b), 32'd0);
    check("c4_busy", 32'(busy_cnt - busy_b), 32'd0);
    check("c4_pulses", 32'(done_cnt - done_b), 32'd1);

    // stalls and a re-pulsed start that must be ignored
    ar_delay = 3; w_toggle = 1;
    do_xfer(32'h4000, 32'h5000, 16'd6, 3);
    repeat (10) @(negedge ACLK);
    chk_counts("c5", 1, 1, 6);
    chk_addr("c5_ar", 0, 0, 32'h4000, 4'd5);
    chk_addr("c5_aw", 1, 0, 32'h5000, 4'd5);
    chk_data("c5", 32'h4000, 6);
    chk_last("c5", 5);
    ar_delay = 0; w_toggle = 0;

    // error response on the first burst of two
    err_burst = b_cnt;
    do_xfer(32'h1000, 32'h2000, 16'd32, 0);
    err_burst = -1;
    check("c6_err", 32'(err), 32'd1);
`ifdef DMA_ERR_ABORT_EN
    chk_counts("c6", 1, 1, 16);
    chk_addr("c6_ar0", 0, 0, 32'h1000, 4'd15);
`else
    chk_counts("c6", 2, 2, 32);
    chk_addr("c6_ar1", 0, 1, 32'h1040, 4'd15);
    chk_addr("c6_aw1", 1, 1, 32'h2040, 4'd15);
    chk_data("c6", 32'h1000, 32);
`endif

    // a clean transfer clears the sticky error
    do_xfer(32'h0100, 32'h0200, 16'd2, 0);
    check("c7_err_clr", 32'(err), 32'd0);
    chk_addr("c7_ar", 0, 0, 32'h0100, 4'd1);
    chk_data("c7", 32'h0100, 2);

    // reset in the middle of a transfer
    @(negedge ACLK); src_addr = 32'h1000; dst_addr = 32'h2000; len = 16'd16; start = 1;
    @(negedge ACLK); start = 0;
    repeat (8) @(negedge ACLK);
    check("c8_busy_pre", 32'(busy), 32'd1);
    ARESETn = 0;
    @(negedge ACLK);
    check("c8_reset_ctrl",
          {24'd0, busy, done, err, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M}, 32'd0);
    ARESETn = 1;
    repeat (2) @(negedge ACLK);
    do_xfer(32'h6000, 32'h7000, 16'd3, 0);
    chk_counts("c9", 1, 1, 3);
    chk_data("c9", 32'h6000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
